// File: rtl/up_exec_unit.sv
// Instruction execution unit: accepts 8-bit instructions, reads two register-block ports,
// runs the ALU and writes the result back while maintaining zero/carry flags.
module up_exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              ins_valid_i,
    input  logic [7:0]        ins_data_i,
    output logic              ins_ready_o,
    output logic [1:0]        rf_sel_out_a_o,
    output logic [1:0]        rf_sel_out_b_o,
    input  logic [DATA_W-1:0] rf_data_a_i,
    input  logic [DATA_W-1:0] rf_data_b_i,
    output logic [1:0]        rf_sel_in_o,
    output logic [DATA_W-1:0] rf_data_in_o,
    output logic              rf_we_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a byte transfers on a rising edge where ins_valid_i and ins_ready_o are both high;
    // the producer holds ins_data_i stable until then.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_IMM = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                           OP_SHL = 4'h8, OP_SHR = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
                           OP_LDI = 4'hC, OP_CMP = 4'hD;
    localparam logic [DATA_W:0] ONE_W = 1;

    state_t            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              z_q, z_d, c_q, c_d;
    logic [3:0]        op;
    logic              op_illegal, op_writes;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, upd_z, upd_c;

    assign op         = ir_q[7:4];
    assign op_illegal = (op == 4'hE) || (op == 4'hF);
    assign op_writes  = !op_illegal && (op != OP_NOP) && (op != OP_CMP);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ins_valid_i) state_d = (ins_data_i[7:4] == OP_LDI) ? S_IMM : S_EXEC;
            S_IMM:  if (ins_valid_i) state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ins_ready_o = (state_q == S_IDLE) || (state_q == S_IMM);
        busy_o      = (state_q != S_IDLE);
        rf_we_o     = (state_q == S_WB) && op_writes;
        err_o       = (state_q == S_WB) && op_illegal;
        dbg_state_o = state_q;
    end

    assign rf_sel_out_a_o = ir_q[3:2];
    assign rf_sel_out_b_o = ir_q[1:0];
    assign rf_sel_in_o    = ir_q[3:2];
    assign rf_data_in_o   = res_q;
    assign flag_z_o       = z_q;
    assign flag_c_o       = c_q;

    // Carry and borrow both fall out of bit DATA_W of a one-bit-wider add/subtract.
    always_comb begin
        wide    = '0;
        alu_res = res_q;
        alu_c   = c_q;
        upd_z   = 1'b1;
        upd_c   = 1'b0;
        case (op)
            OP_MOV: alu_res = rf_data_b_i;
            OP_ADD: begin wide = {1'b0, rf_data_a_i} + {1'b0, rf_data_b_i}; upd_c = 1'b1; end
            OP_SUB, OP_CMP: begin wide = {1'b0, rf_data_a_i} - {1'b0, rf_data_b_i}; upd_c = 1'b1; end
            OP_AND: alu_res = rf_data_a_i & rf_data_b_i;
            OP_OR:  alu_res = rf_data_a_i | rf_data_b_i;
            OP_XOR: alu_res = rf_data_a_i ^ rf_data_b_i;
            OP_NOT: alu_res = ~rf_data_b_i;
            OP_SHL: begin alu_res = {rf_data_a_i[DATA_W-2:0], 1'b0}; alu_c = rf_data_a_i[DATA_W-1]; upd_c = 1'b1; end
            OP_SHR: begin alu_res = {1'b0, rf_data_a_i[DATA_W-1:1]}; alu_c = rf_data_a_i[0]; upd_c = 1'b1; end
            OP_INC: begin wide = {1'b0, rf_data_a_i} + ONE_W; upd_c = 1'b1; end
            OP_DEC: begin wide = {1'b0, rf_data_a_i} - ONE_W; upd_c = 1'b1; end
            OP_LDI: alu_res = imm_q;
            default: upd_z = 1'b0;
        endcase
        if (op == OP_ADD || op == OP_SUB || op == OP_CMP || op == OP_INC || op == OP_DEC) begin
            alu_res = wide[DATA_W-1:0];
            alu_c   = wide[DATA_W];
        end
    end

    always_comb begin
        ir_d  = ir_q;
        imm_d = imm_q;
        res_d = res_q;
        z_d   = z_q;
        c_d   = c_q;
        if (state_q == S_IDLE && ins_valid_i) ir_d = ins_data_i;
        if (state_q == S_IMM && ins_valid_i) imm_d = DATA_W'(ins_data_i);
        if (state_q == S_EXEC) begin
            res_d = alu_res;
            if (upd_z) z_d = (alu_res == '0);
            if (upd_c) c_d = alu_c;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ir_q  <= '0;
            imm_q <= '0;
            res_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            imm_q <= imm_d;
            res_q <= res_d;
            z_q   <= z_d;
            c_q   <= c_d;
        end
    end

endmodule

// File: tb/tb_up_exec_unit.sv
// Bench for up_exec_unit: a 4-entry register block model, a reference ISA model feeding an
// expected queue at each instruction handshake, and a write-back monitor that pops it.
module tb_up_exec_unit;

  localparam int W = 14;  // {err, we, sel[1:0], data[7:0], z, c}

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       ins_valid = 1'b0;
  logic [7:0] ins_data = 8'h00;
  logic       ins_ready;
  logic [1:0] rf_sel_out_a, rf_sel_out_b, rf_sel_in;
  logic [7:0] rf_data_a, rf_data_b, rf_data_in;
  logic       rf_we, flag_z, flag_c, busy, err;
  logic [1:0] dbg_state;

  logic [7:0] rf [4];
  logic       rf_init = 1'b1;
  logic [7:0] m_r [4];
  logic       m_z, m_c;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  up_exec_unit #(.DATA_W(8)) dut (
    .clk(clk), .nRst(nRst),
    .ins_valid_i(ins_valid), .ins_data_i(ins_data), .ins_ready_o(ins_ready),
    .rf_sel_out_a_o(rf_sel_out_a), .rf_sel_out_b_o(rf_sel_out_b),
    .rf_data_a_i(rf_data_a), .rf_data_b_i(rf_data_b),
    .rf_sel_in_o(rf_sel_in), .rf_data_in_o(rf_data_in), .rf_we_o(rf_we),
    .flag_z_o(flag_z), .flag_c_o(flag_c), .busy_o(busy), .err_o(err),
    .dbg_state_o(dbg_state)
  );

  // clock / register block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_data_a = rf[rf_sel_out_a];
  assign rf_data_b = rf[rf_sel_out_b];

  always @(posedge clk) begin
    if (rf_init) begin
      rf[0] <= 8'h01; rf[1] <= 8'h02; rf[2] <= 8'h03; rf[3] <= 8'h04;
    end else if (rf_we) begin
      rf[rf_sel_in] <= rf_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model of one instruction; result pushed for the write-back cycle
  task automatic push_exp(input logic [7:0] ins, input logic [7:0] imm, input int h);
    logic [3:0] op;
    logic [1:0] ra, rb;
    logic [7:0] a, b, r;
    logic [8:0] w;
    logic       we, er, uz, uc, nc;
    op = ins[7:4]; ra = ins[3:2]; rb = ins[1:0];
    a = m_r[ra]; b = m_r[rb];
    we = 1'b1; er = 1'b0; uz = 1'b1; uc = 1'b0; nc = m_c; r = 8'h00;
    case (op)
      4'h0: begin we = 1'b0; uz = 1'b0; end
      4'h1: r = b;
      4'h2: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; nc = w[8]; uc = 1'b1; end
      4'h3: begin r = a - b; nc = (a < b); uc = 1'b1; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~b;
      4'h8: begin r = {a[6:0], 1'b0}; nc = a[7]; uc = 1'b1; end
      4'h9: begin r = {1'b0, a[7:1]}; nc = a[0]; uc = 1'b1; end
      4'hA: begin r = a + 8'd1; nc = (a == 8'hFF); uc = 1'b1; end
      4'hB: begin r = a - 8'd1; nc = (a == 8'h00); uc = 1'b1; end
      4'hC: r = imm;
      4'hD: begin r = a - b; nc = (a < b); uc = 1'b1; we = 1'b0; end
      default: begin we = 1'b0; er = 1'b1; uz = 1'b0; end
    endcase
    if (uz) m_z = (r == 8'h00);
    if (uc) m_c = nc;
    if (we) m_r[ra] = r;
    exp_q.push_back({er, we, ra, r, m_z, m_c});
    exp_cyc_q.push_back(h + 2);
  endtask

  // write-back monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    int ec;
    if (nRst && dbg_state == 2'd3) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("wb_cycle", cyc, ec);
        check("wb_err", err, e[13]);
        check("wb_we", rf_we, e[12]);
        if (e[12]) begin
          check("wb_sel", rf_sel_in, e[11:10]);
          check("wb_data", rf_data_in, e[9:2]);
        end
        check("wb_z", flag_z, e[1]);
        check("wb_c", flag_c, e[0]);
        check("wb_busy_ready", {busy, ins_ready}, 2'b10);
      end
    end
  end

  // driver tasks
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {ins_ready, busy, rf_we, err}, 4'b1000);
    check({tag, "_sel"}, {rf_sel_out_a, rf_sel_out_b, rf_sel_in}, 6'd0);
    check({tag, "_data"}, rf_data_in, 8'h00);
    check({tag, "_flags"}, {flag_z, flag_c}, 2'b00);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic reset_all();
    @(negedge clk);
    nRst = 1'b0; ins_valid = 1'b0; rf_init = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rf_init = 1'b0; nRst = 1'b1;
    m_r[0] = 8'h01; m_r[1] = 8'h02; m_r[2] = 8'h03; m_r[3] = 8'h04;
    m_z = 1'b0; m_c = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int h);
    bit done;
    done = 1'b0;
    h = cyc;
    @(negedge clk);
    ins_valid = 1'b1; ins_data = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (ins_ready) begin
        h = cyc;
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_instr(input logic [7:0] b, input logic [7:0] imm, output int h);
    send_byte(b, h);
    if (b[7:4] == 4'hC) send_byte(imm, h);
    push_exp(b, imm, h);
  endtask

  task automatic idle();
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    idle();
    for (int i = 0; i < 20 && !done; i++) begin
      if (!busy && exp_q.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h, h1, h2, h3;
    reset_all();

    // ADD r0,r1
    send_instr(8'h21, 8'h00, h);
    wait_idle();

    // LDI r2 with a stalled immediate, then INC r2
    reset_all();
    send_byte(8'hC8, h);
    idle();
    repeat (5) @(negedge clk);
    check("imm_wait", {dbg_state, ins_ready, busy}, 4'b0111);
    send_byte(8'hFF, h);
    push_exp(8'hC8, 8'hFF, h);
    send_instr(8'hA8, 8'h00, h);
    wait_idle();

    // SUB r0,r3 then CMP r3,r3
    reset_all();
    send_instr(8'h33, 8'h00, h);
    send_instr(8'hDF, 8'h00, h);
    wait_idle();

    // three back-to-back ADD r0,r1 with ins_valid held high
    reset_all();
    send_instr(8'h21, 8'h00, h1);
    send_instr(8'h21, 8'h00, h2);
    send_instr(8'h21, 8'h00, h3);
    check("b2b_gap1", h2 - h1, 32'd3);
    check("b2b_gap2", h3 - h2, 32'd3);
    wait_idle();
    check("b2b_r0", rf[0], 8'h07);

    // illegal opcode after a borrow, so flag preservation is visible
    reset_all();
    send_instr(8'h33, 8'h00, h);
    send_instr(8'hE0, 8'h00, h);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("illegal_after_cycle", cyc, h + 3);
    check("illegal_after", {ins_ready, busy, err, rf_we}, 4'b1000);
    check("illegal_flags", {flag_z, flag_c}, 2'b01);

    // random mix, including LDI immediates and illegal opcodes
    reset_all();
    for (int i = 0; i < 40; i++) begin
      send_instr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), h);
      if ($urandom_range(0, 3) == 0) idle();
    end
    wait_idle();
    for (int i = 0; i < 4; i++) check($sformatf("rand_r%0d", i), rf[i], m_r[i]);

    // reset asserted during WB of ADD r1,r1
    reset_all();
    send_instr(8'h25, 8'h00, h);
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_wb_pre_we", rf_we, 1'b1);
    exp_q.delete();
    exp_cyc_q.delete();
    nRst = 1'b0;
    #1;
    check_reset_outputs("rst_wb");
    @(posedge clk);
    #1;
    check("rst_wb_r1", rf[1], 8'h02);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
